// File: rtl/muldiv_seq_if.sv
// Request/response handshake bundle for the muldiv_seq sequencer.
// master = execute stage, slave = sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;

    modport master (
        output in_valid, op, src1, src2,
        output flush, out_ready,
        input  in_ready, out_valid,
        input  result, illegal
    );

    modport slave (
        input  in_valid, op, src1, src2,
        input  flush, out_ready,
        output in_ready, out_valid,
        output result, illegal
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV64M multi-cycle mul/div sequencer: shift-add multiply, restoring divide.
// Define MULDIV_WORD_OPS_EN to enable the W ops (8, 12-15).
module muldiv_seq #(
    parameter int XLEN = 64
) (
    input logic        clk,
    input logic        rst_n,
    muldiv_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE, CALC, FIX, DONE
    } state_t;

    state_t state, state_nxt;
    logic [5:0] cnt, cnt_nxt;

    logic [127:0]    prod;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic            neg_q;
    logic            neg_r;
    logic [2:0]      op_q;

    logic acc, is_div, in_w, illegal_op;
    logic sgn1, sgn2, neg1, neg2;
    logic div_zero, ovf, fast;
    logic [63:0] x1, x2, x1_sx;
    logic [63:0] abs1, abs2, min_val;
    logic [63:0] fast_res;

    assign acc    = (state == IDLE) & bus.in_valid & ~bus.flush;
    assign is_div = bus.op[2];

`ifdef MULDIV_WORD_OPS_EN
    logic w_q;

    assign in_w = bus.op[3] & (bus.op[2] | (bus.op[1:0] == 2'b00));
    assign illegal_op = bus.op[3] & ~bus.op[2]
                      & (bus.op[1:0] != 2'b00);
    assign x1 = in_w ? {{32{sgn1 & bus.src1[31]}}, bus.src1[31:0]}
                     : bus.src1;
    assign x2 = in_w ? {{32{sgn2 & bus.src2[31]}}, bus.src2[31:0]}
                     : bus.src2;
    assign x1_sx = in_w ? {{32{bus.src1[31]}}, bus.src1[31:0]}
                        : bus.src1;
    assign min_val = in_w ? 64'hFFFF_FFFF_8000_0000
                          : 64'h8000_0000_0000_0000;
`else
    assign in_w       = 1'b0;
    assign illegal_op = bus.op[3];
    assign x1         = bus.src1;
    assign x2         = bus.src2;
    assign x1_sx      = bus.src1;
    assign min_val    = 64'h8000_0000_0000_0000;
`endif

    // MULW only needs the low 32 product bits, so it runs unsigned
    assign sgn1 = is_div ? ~bus.op[0]
                         : (bus.op[1:0] != 2'b11) & ~in_w;
    assign sgn2 = is_div ? ~bus.op[0]
                         : ~bus.op[1] & ~in_w;

    assign neg1 = sgn1 & x1[63];
    assign neg2 = sgn2 & x2[63];
    assign abs1 = neg1 ? -x1 : x1;
    assign abs2 = neg2 ? -x2 : x2;

    assign div_zero = is_div & ~illegal_op & (x2 == 64'd0);
    assign ovf      = is_div & ~illegal_op & sgn1
                    & (x1 == min_val) & (&x2);
    assign fast     = illegal_op | div_zero | ovf;

    always_comb begin
        fast_res = '0;
        unique case (1'b1)
            illegal_op: fast_res = '0;
            div_zero:   fast_res = bus.op[1] ? x1_sx : '1;
            ovf:        fast_res = bus.op[1] ? '0 : x1;
            default:    fast_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (acc) begin
                    state_nxt = fast ? DONE : CALC;
`ifdef MULDIV_WORD_OPS_EN
                    cnt_nxt = in_w ? 6'd31 : 6'd63;
`else
                    cnt_nxt = 6'd63;
`endif
                end
            end
            CALC: begin
                if (cnt == 6'd0) state_nxt = FIX;
                else cnt_nxt = cnt - 6'd1;
            end
            FIX:  state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    logic [64:0]  sum;
    logic [64:0]  r65;
    logic         ge;
    logic [63:0]  sub;
    logic [127:0] step;

    always_comb begin
        sum  = {1'b0, prod[127:64]}
             + (prod[0] ? {1'b0, dvs} : 65'd0);
        r65  = {prod[127:64], prod[63]};
        ge   = r65 >= {1'b0, dvs};
        sub  = r65[63:0] - dvs;
        step = op_q[2]
             ? {(ge ? sub : r65[63:0]), prod[62:0], ge}
             : {sum, prod[63:1]};
    end

    logic [127:0] pneg;
    logic [63:0]  qv, rv, fix_res;

    always_comb begin
        pneg = neg_q ? -prod : prod;
        qv   = neg_q ? -prod[63:0] : prod[63:0];
        rv   = neg_r ? -prod[127:64] : prod[127:64];
        if (op_q[2])
            fix_res = op_q[1] ? rv : qv;
        else
            fix_res = (op_q[1:0] == 2'b00) ? pneg[63:0]
                                           : pneg[127:64];
`ifdef MULDIV_WORD_OPS_EN
        // W multiply ran 32 steps, so its low word sits at [63:32]
        if (w_q)
            fix_res = op_q[2]
                    ? {{32{fix_res[31]}}, fix_res[31:0]}
                    : {{32{prod[63]}}, prod[63:32]};
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod      <= '0;
            dvs       <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            op_q      <= 3'd0;
`ifdef MULDIV_WORD_OPS_EN
            w_q       <= 1'b0;
`endif
        end else if (acc) begin
            op_q      <= bus.op[2:0];
            neg_q     <= neg1 ^ neg2;
            neg_r     <= neg1;
            illegal_q <= illegal_op;
            if (fast) result_q <= fast_res;
`ifdef MULDIV_WORD_OPS_EN
            w_q <= in_w;
            if (is_div) begin
                prod <= {64'd0, in_w ? {abs1[31:0], 32'd0} : abs1};
                dvs  <= abs2;
            end else begin
                prod <= {64'd0, abs2};
                dvs  <= abs1;
            end
`else
            prod <= {64'd0, is_div ? abs1 : abs2};
            dvs  <= is_div ? abs2 : abs1;
`endif
        end else if (state == CALC) begin
            prod <= step;
        end else if (state == FIX) begin
            result_q  <= fix_res;
            illegal_q <= 1'b0;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle sequencer for the RV64M multiply/divide datapath in the NPC execute stage. It accepts one operation at a time from the decode/execute handshake. It iterates a shared shift-add multiplier / restoring divider one bit per cycle and returns the result with a valid/ready handshake. The execute stage stalls on `in_ready`/`out_valid` while it is busy.

## Interface
Parameters:
- `XLEN`, 64, operand/result width; fixed at 64 for this core.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operation request
- `in_ready`  out  1  high only in IDLE
- `op`  in  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW; 9–11 illegal
- `src1`, `src2`  in  64  operands, sampled on accept
- `flush`  in  1  kill in-flight operation (pipeline redirect)
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts result
- `result`  out  64  final result
- `illegal`  out  1  qualifies `result` when `out_valid`; op not supported

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: an accept (`in_valid && in_ready`) latches the operands as absolute values where signed, plus sign flags.
  - W ops use the low 32 bits; the signed forms sign-extend them and the unsigned forms zero-extend them.
  - On accept, the FSM loads `cnt = N-1`, with N = 64 (full) or 32 (W), and goes to CALC.
- Fast path, IDLE → DONE directly, no CALC:
  - Divide by zero: quotient all ones; remainder = dividend (W: sign-extended low 32).
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0.
  - Illegal op (9–11, or W ops without the macro): result 0, `illegal`=1.
- CALC:
  - Multiply: one shift-add step per cycle into a 128-bit product register.
  - Divide: one restoring subtract/shift step per cycle.
  - When `cnt == 0`, go to FIX; otherwise decrement `cnt`.
- FIX:
  - Apply sign correction: negate the product if operand signs differ; quotient sign = s1^s2; remainder sign = s1.
  - Select the output: low 64 bits for MUL; high 64 bits for MULH/MULHSU/MULHU; quotient or remainder for div/rem.
  - W ops: sign-extend bit 31 to 64 bits.
  - Go to DONE.
- DONE: `out_valid`=1; `result` and `illegal` are held stable until `out_valid && out_ready`, then go to IDLE.
- `flush` in any state: next state IDLE, `out_valid` deasserted, result discarded. `flush` has priority over an accept in the same cycle, so no accept occurs.
- Reset, including mid-operation: state IDLE, `out_valid`=0, `result`=0, `illegal`=0, `cnt`=0, internal registers 0. `in_ready` is 1 in the cycle after reset deasserts.

## Timing
- Accept in cycle k:
  - Iterative ops: CALC is cycles k+1..k+N, FIX is k+N+1, and `out_valid` is first high in cycle k+N+2. Latency is 66 (full) or 34 (W).
  - Fast path: `out_valid` is high in cycle k+1.
- Result handshake completing in cycle j: `in_ready`=1 in cycle j+1. There is no back-to-back accept in the same cycle as the result handshake.
- `out_valid` never drops without a handshake, flush or reset.
- Outputs are registered; there is no combinational path from inputs to `out_valid`/`result`. `in_ready` decodes the state register only.

## Configuration
- `MULDIV_WORD_OPS_EN` defined:
  - Ops 8, 12–15 execute as specified, with N=32.
- `MULDIV_WORD_OPS_EN` undefined:
  - Ops 8, 12–15 are illegal and take the fast path (`result`=0, `illegal`=1, latency 1).
  - The 32-bit sign-extension logic and the N=32 counter load are not compiled.

## Test plan
- MUL `src1`=7, `src2`=0xFFFFFFFFFFFFFFFD → `result`=0xFFFFFFFFFFFFFFEB, `out_valid` 66 cycles after accept.
- DIV −7/2 → 0xFFFFFFFFFFFFFFFD; REM −7/2 → 0xFFFFFFFFFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFFFFFFFFFF at k+1. DIV 0x8000000000000000 / −1 → 0x8000000000000000; REM of the same operands → 0.
- MULW 0x7FFFFFFF×2 → 0xFFFFFFFFFFFFFFFE at latency 34. Without the macro: `illegal`=1, `result`=0 at k+1. MULHU all-ones×all-ones → 0xFFFFFFFFFFFFFFFE.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE → `result` stable and `in_ready`=0. Handshake → `in_ready`=1 the next cycle.
- `flush` at CALC cycle 10 → IDLE next cycle, no `out_valid`. `rst_n`=0 mid-CALC → all outputs 0 and `in_ready`=1 after release.
